// File: rtl/aes_key_sched_seq_if.sv
// aes_key_sched_seq_if
//   Bundles the two streaming handshakes of the AES-128 key scheduler.
//   Key side:   key_valid / key_ready / key_in (128-bit cipher key, w0 in [127:96]).
//   Round side: rk_valid / rk_ready / rk_out (128-bit round key), rk_idx (0..NR),
//               rk_last (final round key of the current cipher key).
//
// Handshake semantics (both channels): a transfer happens on a rising clk edge
// where valid and ready are both high. A producer that raised valid keeps valid
// and its payload stable until that transfer; ready may toggle freely and must
// not be a function of the producer's payload.
//
// Modports:
//   master - the environment: supplies keys, consumes round keys.
//   slave  - the key scheduler.
interface aes_key_sched_seq_if;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] key_in;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_idx;
    logic         rk_last;

    modport master (
        output key_valid, key_in, rk_ready,
        input  key_ready, rk_valid, rk_out, rk_idx, rk_last
    );

    modport slave (
        input  key_valid, key_in, rk_ready,
        output key_ready, rk_valid, rk_out, rk_idx, rk_last
    );
endinterface

// File: rtl/aes_key_sched_seq.sv
// aes_key_sched_seq
//   Iterative AES-128 key schedule. Takes one cipher key, then emits round
//   keys 0..NR one per round-key handshake, computing each next key from the
//   registered current key with four S-box lookups.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus        aes_key_sched_seq_if.slave (key and round-key handshakes)
//   dbg_state  current FSM state (0 = IDLE, 1 = EMIT)
//
// Parameter NR: number of rounds, 1..10; NR+1 round keys per cipher key.
module aes_key_sched_seq #(
    parameter int NR = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    aes_key_sched_seq_if.slave        bus,
    output logic                      dbg_state
);

    if ((NR < 1) || (NR > 10)) begin : g_nr_check
        $error("aes_key_sched_seq: NR=%0d is outside 1..10", NR);
    end

    localparam logic [3:0] LAST_IDX = 4'(NR);

    // AES S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] base;
        base = 11'd2047 - {x, 3'b000};
        return SBOX_TBL[base -: 8];
    endfunction

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    state_e       state_q,  state_d;
    logic [127:0] rk_out_q, rk_out_d;
    logic [3:0]   rk_idx_q, rk_idx_d;
    logic [7:0]   rcon_q,   rcon_d;

    logic [31:0]  rot_w3;
    logic [31:0]  sub_w3;
    logic [31:0]  t_word;
    logic [31:0]  n0, n1, n2, n3;
    logic [7:0]   rcon_next;

    // Next-round-key datapath: the only logic between rk_out_q and rk_out_d.
    always_comb begin
        rot_w3    = {rk_out_q[23:0], rk_out_q[31:24]};
        sub_w3    = {sbox(rot_w3[31:24]), sbox(rot_w3[23:16]),
                     sbox(rot_w3[15:8]),  sbox(rot_w3[7:0])};
        t_word    = sub_w3 ^ {rcon_q, 24'h0};
        n0        = rk_out_q[127:96] ^ t_word;
        n1        = rk_out_q[95:64]  ^ n0;
        n2        = rk_out_q[63:32]  ^ n1;
        n3        = rk_out_q[31:0]   ^ n2;
        rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
    end

    always_comb begin
        state_d  = state_q;
        rk_out_d = rk_out_q;
        rk_idx_d = rk_idx_q;
        rcon_d   = rcon_q;
        case (state_q)
            IDLE: begin
                if (bus.key_valid) begin
                    rk_out_d = bus.key_in;
                    rk_idx_d = 4'd0;
                    rcon_d   = 8'h01;
                    state_d  = EMIT;
                end
            end
            EMIT: begin
                if (bus.rk_ready) begin
                    if (rk_idx_q == LAST_IDX) begin
                        // Last key consumed; rk_out/rk_idx are left as-is.
                        state_d = IDLE;
                    end else begin
                        rk_out_d = {n0, n1, n2, n3};
                        rk_idx_d = rk_idx_q + 4'd1;
                        rcon_d   = rcon_next;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rk_out_q <= 128'h0;
            rk_idx_q <= 4'd0;
            rcon_q   <= 8'h01;
        end else begin
            state_q  <= state_d;
            rk_out_q <= rk_out_d;
            rk_idx_q <= rk_idx_d;
            rcon_q   <= rcon_d;
        end
    end

    assign bus.key_ready = (state_q == IDLE);
    assign bus.rk_valid  = (state_q == EMIT);
    assign bus.rk_out    = rk_out_q;
    assign bus.rk_idx    = rk_idx_q;
    assign bus.rk_last   = (state_q == EMIT) && (rk_idx_q == LAST_IDX);
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_aes_key_sched_seq.sv
// tb_aes_key_sched_seq
//   Directed bench for aes_key_sched_seq: an NR=10 instance exercises the
//   FIPS-197 vectors, backpressure, back-to-back keys, mid-sequence reset and
//   ignored key_in; an NR=1 instance checks the short build.
module tb_aes_key_sched_seq;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_key_sched_seq_if b10 ();
    aes_key_sched_seq_if b1 ();
    logic dbg10;
    logic dbg1;

    aes_key_sched_seq #(.NR(10)) dut10 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (b10.slave),
        .dbg_state (dbg10)
    );

    aes_key_sched_seq #(.NR(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (b1.slave),
        .dbg_state (dbg1)
    );

    // ---------------- reference vectors ----------------
    localparam logic [127:0] KEY_A1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_C1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY_FF  = {128{1'b1}};

    logic [127:0] a1_rk [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    // ---------------- scoreboard ----------------
    logic [127:0] exp_q[$];
    int           exp_idx_q[$];
    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_rk(input int idx, input logic [127:0] val);
        exp_idx_q.push_back(idx);
        exp_q.push_back(val);
    endtask

    task automatic expect_a1(input int upto);
        for (int i = 0; i <= upto; i++) expect_rk(i, a1_rk[i]);
    endtask

    // ---------------- driver tasks (called right after a negedge) ----------------
    task automatic send_key(input logic [127:0] k);
        int cyc;
        cyc = 0;
        b10.key_in    = k;
        b10.key_valid = 1'b1;
        while (!b10.key_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        b10.key_valid = 1'b0;
        check("accept_valid", 128'(b10.rk_valid), 128'(1));
        check("accept_idx0", 128'(b10.rk_idx), 128'(0));
    endtask

    // Consume n_keys round keys, dropping rk_ready stall_pct percent of the time.
    // Returns at the negedge after the last transfer.
    task automatic consume(input int n_keys, input int stall_pct, input bit disturb,
                           output int cycles);
        int           got;
        bit           stalled;
        bit           r;
        logic [127:0] held_out;
        logic [3:0]   held_idx;
        got = 0;
        cycles = 0;
        stalled = 1'b0;
        held_out = '0;
        held_idx = '0;
        while (got < n_keys && cycles < 400) begin
            if (stalled) begin
                check("stall_out", b10.rk_out, held_out);
                check("stall_idx", 128'(b10.rk_idx), 128'(held_idx));
                check("stall_valid", 128'(b10.rk_valid), 128'(1));
            end
            stalled = 1'b0;
            if (b10.rk_valid) begin
                check("busy_key_ready", 128'(b10.key_ready), 128'(0));
                r = ($urandom_range(99) >= 32'(stall_pct));
                if (r) begin
                    check("rk_idx", 128'(b10.rk_idx), 128'(got));
                    check("rk_last", 128'(b10.rk_last), 128'(got == 10));
                    if (exp_idx_q.size() > 0 && exp_idx_q[0] == got) begin
                        void'(exp_idx_q.pop_front());
                        check($sformatf("rk_out_idx%0d", got), b10.rk_out, exp_q.pop_front());
                    end
                    got++;
                end else begin
                    stalled  = 1'b1;
                    held_out = b10.rk_out;
                    held_idx = b10.rk_idx;
                end
                b10.rk_ready = r;
            end else begin
                b10.rk_ready = 1'b1;
            end
            if (disturb) begin
                b10.key_in    = {$urandom(), $urandom(), $urandom(), $urandom()};
                b10.key_valid = 1'($urandom_range(1));
            end
            @(negedge clk);
            cycles++;
        end
        if (disturb) b10.key_valid = 1'b0;
        if (got < n_keys) check("consume_timeout", 128'(got), 128'(n_keys));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int cyc;
        b10.key_valid = 1'b0;
        b10.key_in    = '0;
        b10.rk_ready  = 1'b0;
        b1.key_valid  = 1'b0;
        b1.key_in     = '0;
        b1.rk_ready   = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_key_ready", 128'(b10.key_ready), 128'(1));
        check("rst_rk_valid", 128'(b10.rk_valid), 128'(0));
        check("rst_rk_last", 128'(b10.rk_last), 128'(0));
        check("rst_rk_out", b10.rk_out, 128'h0);
        check("rst_rk_idx", 128'(b10.rk_idx), 128'(0));
        check("rst_dbg_state", 128'(dbg10), 128'(0));
        check("rst_nr1_key_ready", 128'(b1.key_ready), 128'(1));
        check("rst_nr1_rk_valid", 128'(b1.rk_valid), 128'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // FIPS-197 A.1, rk_ready always high: 11 keys in 11 cycles
        b10.rk_ready = 1'b1;
        send_key(KEY_A1);
        check("emit_dbg_state", 128'(dbg10), 128'(1));
        expect_a1(10);
        consume(11, 0, 1'b0, cyc);
        check("a1_cycles", 128'(cyc), 128'(11));
        check("a1_done_valid", 128'(b10.rk_valid), 128'(0));
        check("a1_done_key_ready", 128'(b10.key_ready), 128'(1));

        // Backpressure: random 50% stalls, identical sequence
        send_key(KEY_A1);
        expect_a1(10);
        consume(11, 50, 1'b0, cyc);
        check("bp_done_valid", 128'(b10.rk_valid), 128'(0));

        // key_in ignored while emitting
        send_key(KEY_A1);
        expect_a1(10);
        consume(11, 25, 1'b1, cyc);
        check("ign_done_valid", 128'(b10.rk_valid), 128'(0));
        @(negedge clk);
        check("ign_stays_idle", 128'(b10.rk_valid), 128'(0));

        // Back-to-back keys with key_valid held high
        b10.rk_ready  = 1'b1;
        b10.key_in    = KEY_C1;
        b10.key_valid = 1'b1;
        expect_rk(0, KEY_C1);
        expect_rk(1, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
        expect_rk(10, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        @(negedge clk);
        check("b2b_first_valid", 128'(b10.rk_valid), 128'(1));
        b10.key_in = KEY_FF;
        consume(11, 0, 1'b0, cyc);
        check("b2b_gap_key_ready", 128'(b10.key_ready), 128'(1));
        check("b2b_gap_valid", 128'(b10.rk_valid), 128'(0));
        expect_rk(0, KEY_FF);
        expect_rk(1, 128'he8e9e9e917161616e8e9e9e917161616);
        @(negedge clk);
        check("b2b_second_valid", 128'(b10.rk_valid), 128'(1));
        b10.key_valid = 1'b0;
        consume(11, 0, 1'b0, cyc);
        check("b2b_done_valid", 128'(b10.rk_valid), 128'(0));

        // Reset while idx 5 is on the bus
        send_key(KEY_A1);
        expect_a1(4);
        consume(5, 0, 1'b0, cyc);
        check("mid_idx5", 128'(b10.rk_idx), 128'(5));
        check("mid_rk5", b10.rk_out, a1_rk[5]);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 128'(b10.rk_valid), 128'(0));
        check("mid_rst_key_ready", 128'(b10.key_ready), 128'(1));
        check("mid_rst_rk_out", b10.rk_out, 128'h0);
        check("mid_rst_rk_last", 128'(b10.rk_last), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", 128'(b10.rk_valid), 128'(0));
        send_key(KEY_A1);
        expect_a1(10);
        consume(11, 0, 1'b0, cyc);
        check("scoreboard_empty", 128'(exp_q.size()), 128'(0));

        // NR=1 build
        b1.rk_ready  = 1'b1;
        b1.key_in    = KEY_A1;
        b1.key_valid = 1'b1;
        @(negedge clk);
        b1.key_valid = 1'b0;
        check("nr1_valid0", 128'(b1.rk_valid), 128'(1));
        check("nr1_rk0", b1.rk_out, KEY_A1);
        check("nr1_idx0", 128'(b1.rk_idx), 128'(0));
        check("nr1_last0", 128'(b1.rk_last), 128'(0));
        @(negedge clk);
        check("nr1_valid1", 128'(b1.rk_valid), 128'(1));
        check("nr1_rk1", b1.rk_out, a1_rk[1]);
        check("nr1_idx1", 128'(b1.rk_idx), 128'(1));
        check("nr1_last1", 128'(b1.rk_last), 128'(1));
        @(negedge clk);
        check("nr1_done_valid", 128'(b1.rk_valid), 128'(0));
        check("nr1_done_key_ready", 128'(b1.key_ready), 128'(1));

        // ---------------- final report ----------------
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end

endmodule
